// File: rtl/dmem_port_arbiter_pkg.sv
// Shared memory-port types: access sizes, bus commands, arbiter states
// and the latched request packet.
package dmem_port_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ID_W   = 3;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } ARB_STATE;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
        MEM_SIZE           size;
        logic              is_store;
        logic [ID_W-1:0]   id;
    } MEM_REQ_PACKET;

    function automatic logic [63:0] size_mask(input MEM_SIZE size);
        case (size)
            BYTE:    return 64'h0000_0000_0000_00ff;
            HALF:    return 64'h0000_0000_0000_ffff;
            WORD:    return 64'h0000_0000_ffff_ffff;
            default: return '1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and memory-side signals of the shared data-memory port.
interface dmem_port_arbiter_if
#(
    parameter int NUM_LD = 2,
    parameter int XLEN   = dmem_port_arbiter_pkg::DATA_W,
    parameter int TAG_W  = 4
);
    import dmem_port_arbiter_pkg::*;

    logic                     squash;
    logic [NUM_LD-1:0]        ld_req_valid;
    logic [NUM_LD*XLEN-1:0]   ld_req_addr;
    logic [NUM_LD*2-1:0]      ld_req_size;
    logic [NUM_LD-1:0]        ld_req_ready;
    logic [NUM_LD-1:0]        ld_resp_valid;
    logic [XLEN-1:0]          ld_resp_data;
    logic                     st_req_valid;
    logic [XLEN-1:0]          st_req_addr;
    logic [XLEN-1:0]          st_req_data;
    MEM_SIZE                  st_req_size;
    logic                     st_req_ready;
    BUS_COMMAND               proc2mem_command;
    logic [XLEN-1:0]          proc2mem_addr;
    logic [63:0]              proc2mem_data;
    MEM_SIZE                  proc2mem_size;
    logic [TAG_W-1:0]         mem2proc_response;
    logic [63:0]              mem2proc_data;
    logic [TAG_W-1:0]         mem2proc_tag;

    modport master (
        output squash, ld_req_valid, ld_req_addr, ld_req_size,
               st_req_valid, st_req_addr, st_req_data, st_req_size,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ld_req_ready, ld_resp_valid, ld_resp_data, st_req_ready,
               proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

    modport slave (
        input  squash, ld_req_valid, ld_req_addr, ld_req_size,
               st_req_valid, st_req_addr, st_req_data, st_req_size,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output ld_req_ready, ld_resp_valid, ld_resp_data, st_req_ready,
               proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
    );

endinterface

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// N-way round-robin pick; the search begins at an externally held pointer
// so the owner decides when the priority rotates.
module rr_arbiter
#(
    parameter  int N     = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
)
(
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        int slot;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        slot  = 0;
        for (int i = 0; i < N; i++) begin
            slot = (int'(ptr) + i) % N;
            if (!valid && req[slot]) begin
                valid       = 1'b1;
                grant[slot] = 1'b1;
                idx         = PTR_W'(slot);
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single tagged memory port between NUM_LD load requesters and
// the retiring store, with one transaction outstanding at a time.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int NUM_LD = 2,
    parameter int XLEN   = dmem_port_arbiter_pkg::DATA_W,
    parameter int TAG_W  = 4
)
(
    input logic               clock,
    input logic               reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int N     = NUM_LD + 1;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    ARB_STATE         state, state_next;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_next;
    MEM_REQ_PACKET    cur, cur_next, cand;
    logic [TAG_W-1:0] tag, tag_next;

    logic [N-1:0]     req, grant;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic             accepted, tag_hit;
    logic [63:0]      shifted;

    // Store occupies the top slot; a flush makes every load ineligible.
    assign req = {bus.st_req_valid, bus.ld_req_valid & ~{NUM_LD{bus.squash}}};

    rr_arbiter #(.N(N)) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign accepted = bus.mem2proc_response != '0;
    assign tag_hit  = (bus.mem2proc_tag == tag) && (tag != '0);
    assign shifted  = bus.mem2proc_data >> {cur.addr[2:0], 3'b000};

    always_comb begin
        cand = '0;
        if (pick_idx == PTR_W'(NUM_LD)) begin
            cand.addr     = bus.st_req_addr;
            cand.data     = bus.st_req_data;
            cand.size     = bus.st_req_size;
            cand.is_store = 1'b1;
        end else begin
            for (int i = 0; i < NUM_LD; i++) begin
                if (pick_idx == PTR_W'(i)) begin
                    cand.addr = bus.ld_req_addr[i*XLEN +: XLEN];
                    cand.size = MEM_SIZE'(bus.ld_req_size[i*2 +: 2]);
                end
            end
        end
        cand.id = ID_W'(pick_idx);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur    <= '0;
            tag    <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            cur    <= cur_next;
            tag    <= tag_next;
        end
    end

    // NOTE: every next-state and output gets a default first so no path infers a latch.
    always_comb begin
        state_next            = state;
        rr_ptr_next           = rr_ptr;
        cur_next              = cur;
        tag_next              = tag;
        bus.ld_req_ready      = '0;
        bus.ld_resp_valid     = '0;
        bus.ld_resp_data      = '0;
        bus.st_req_ready      = 1'b0;
        bus.proc2mem_command  = BUS_NONE;
        bus.proc2mem_addr     = '0;
        bus.proc2mem_data     = '0;
        bus.proc2mem_size     = BYTE;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_next         = cand;
                        state_next       = ISSUE;
                        bus.ld_req_ready = grant[NUM_LD-1:0];
                    end
                end
                ISSUE: begin
                    bus.proc2mem_command = cur.is_store ? BUS_STORE : BUS_LOAD;
                    bus.proc2mem_addr    = cur.addr;
                    bus.proc2mem_data    = 64'({cur.data, cur.data});
                    bus.proc2mem_size    = cur.size;
                    if (cur.is_store) begin
                        if (accepted) begin
                            bus.st_req_ready = 1'b1;
                            state_next       = IDLE;
                            rr_ptr_next      = '0;
                        end
                    end else if (accepted) begin
                        tag_next   = bus.mem2proc_response;
                        state_next = bus.squash ? DRAIN : WAIT;
                    end else if (bus.squash) begin
                        state_next = IDLE;
                    end
                end
                WAIT: begin
                    // A flush coinciding with the completion simply swallows it.
                    if (bus.squash) begin
                        state_next = tag_hit ? IDLE : DRAIN;
                    end else if (tag_hit) begin
                        for (int i = 0; i < NUM_LD; i++) begin
                            bus.ld_resp_valid[i] = (cur.id == ID_W'(i));
                        end
                        bus.ld_resp_data = XLEN'(shifted & size_mask(cur.size));
                        state_next       = IDLE;
                        rr_ptr_next      = (cur.id == ID_W'(NUM_LD)) ? '0
                                                                     : PTR_W'(cur.id + 1'b1);
                    end
                end
                DRAIN: begin
                    if (tag_hit) state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: the bench plays both requesters and
// the tagged memory, with hand-computed expectations.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dmem_port_arbiter_if #(.NUM_LD(2), .XLEN(32), .TAG_W(4)) bus ();

    dmem_port_arbiter #(.NUM_LD(2), .XLEN(32), .TAG_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.squash            = 1'b0;
        bus.ld_req_valid      = '0;
        bus.ld_req_addr       = '0;
        bus.ld_req_size       = '0;
        bus.st_req_valid      = 1'b0;
        bus.st_req_addr       = '0;
        bus.st_req_data       = '0;
        bus.st_req_size       = BYTE;
        bus.mem2proc_response = '0;
        bus.mem2proc_data     = '0;
        bus.mem2proc_tag      = '0;
    endtask

    task automatic set_ld(input int i, input logic [31:0] a, input logic [1:0] s);
        bus.ld_req_valid[i]        = 1'b1;
        bus.ld_req_addr[i*32 +: 32] = a;
        bus.ld_req_size[i*2 +: 2]   = s;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cmd"},   bus.proc2mem_command, BUS_NONE);
        check({name, "_ldrdy"}, bus.ld_req_ready, 0);
        check({name, "_rspv"},  bus.ld_resp_valid, 0);
        check({name, "_rspd"},  bus.ld_resp_data, 0);
        check({name, "_strdy"}, bus.st_req_ready, 0);
        check({name, "_addr"},  bus.proc2mem_addr, 0);
        check({name, "_data"},  bus.proc2mem_data, 0);
        check({name, "_size"},  bus.proc2mem_size, 0);
    endtask

    // Full load: grant, accept after acc_wait idle cycles, completion after cmp_wait more.
    task automatic do_load(input string name, input int id, input logic [31:0] a,
                           input logic [1:0] s, input int acc_wait, input logic [3:0] t,
                           input int cmp_wait, input logic [63:0] md, input logic [31:0] exp);
        int pulses;
        pulses = 0;
        tick();
        set_ld(id, a, s);
        #1;
        check({name, "_grant"}, bus.ld_req_ready, 64'(1 << id));
        check({name, "_idlecmd"}, bus.proc2mem_command, BUS_NONE);
        tick();
        bus.ld_req_valid = '0;
        for (int c = 0; c <= acc_wait; c++) begin
            if (c == acc_wait) bus.mem2proc_response = t;
            #1;
            check({name, "_cmd"},  bus.proc2mem_command, BUS_LOAD);
            check({name, "_addr"}, bus.proc2mem_addr, a);
            check({name, "_size"}, bus.proc2mem_size, s);
            tick();
        end
        bus.mem2proc_response = '0;
        for (int c = 0; c <= cmp_wait; c++) begin
            if (c == cmp_wait) begin
                bus.mem2proc_tag  = t;
                bus.mem2proc_data = md;
            end
            #1;
            if (bus.ld_resp_valid != 0) pulses++;
            check({name, "_waitcmd"}, bus.proc2mem_command, BUS_NONE);
            if (c == cmp_wait) begin
                check({name, "_rspv"}, bus.ld_resp_valid, 64'(1 << id));
                check({name, "_rspd"}, bus.ld_resp_data, exp);
            end
            tick();
        end
        bus.mem2proc_tag  = '0;
        bus.mem2proc_data = '0;
        #1;
        if (bus.ld_resp_valid != 0) pulses++;
        check({name, "_pulses"}, pulses, 1);
    endtask

    initial begin
        int cnt [3];
        logic [3:0] t;
        int slot;

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        #1;
        check_all_zero("reset");
        tick();
        reset = 1'b0;

        do_load("single", 0, 32'h0000_1004, WORD, 0, 4'd3, 3, 64'hAABBCCDD_11223344, 32'hAABBCCDD);
        do_load("byte",   0, 32'h0000_1003, BYTE, 1, 4'd2, 2, 64'h55667788_44332211, 32'h0000_0044);
        do_load("half",   1, 32'h0000_1002, HALF, 0, 4'd15, 1, 64'h55667788_44332211, 32'h0000_4433);

        // Store held off by the memory for five cycles.
        tick();
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h0000_2008;
        bus.st_req_data  = 32'hDEAD_BEEF;
        bus.st_req_size  = WORD;
        #1;
        check("st_grant_ldrdy", bus.ld_req_ready, 0);
        check("st_grant_strdy", bus.st_req_ready, 0);
        for (int c = 0; c <= 5; c++) begin
            tick();
            if (c == 5) bus.mem2proc_response = 4'd9;
            #1;
            check("st_bp_cmd",  bus.proc2mem_command, BUS_STORE);
            check("st_bp_addr", bus.proc2mem_addr, 32'h0000_2008);
            check("st_bp_data", bus.proc2mem_data, 64'hDEADBEEF_DEADBEEF);
            check("st_bp_size", bus.proc2mem_size, WORD);
            check("st_bp_rdy",  bus.st_req_ready, (c == 5) ? 1 : 0);
        end
        tick();
        bus.mem2proc_response = '0;
        bus.st_req_valid      = 1'b0;
        #1;
        check("st_done_cmd", bus.proc2mem_command, BUS_NONE);
        check("st_done_rdy", bus.st_req_ready, 0);

        // Squash while a load is still waiting for acceptance.
        tick();
        set_ld(0, 32'h0000_4000, WORD);
        #1;
        check("sqi_grant", bus.ld_req_ready, 2'b01);
        tick();
        bus.ld_req_valid = '0;
        bus.squash       = 1'b1;
        #1;
        check("sqi_cmd", bus.proc2mem_command, BUS_LOAD);
        tick();
        bus.squash = 1'b0;
        set_ld(1, 32'h0000_4010, WORD);
        #1;
        check("sqi_dropcmd", bus.proc2mem_command, BUS_NONE);
        check("sqi_regrant", bus.ld_req_ready, 2'b10);
        tick();
        bus.ld_req_valid      = '0;
        bus.mem2proc_response = 4'd6;
        #1;
        check("sqi_addr", bus.proc2mem_addr, 32'h0000_4010);
        tick();
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = 4'd6;
        bus.mem2proc_data     = 64'h0000_0000_CAFE_F00D;
        #1;
        check("sqi_rspv", bus.ld_resp_valid, 2'b10);
        check("sqi_rspd", bus.ld_resp_data, 32'hCAFE_F00D);
        tick();
        bus.mem2proc_tag = '0;

        // Squash hides loads in IDLE but the store still wins.
        bus.squash = 1'b1;
        set_ld(0, 32'h0000_5000, WORD);
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h0000_5001;
        bus.st_req_data  = 32'h1234_5678;
        bus.st_req_size  = BYTE;
        #1;
        check("sqidle_ldrdy", bus.ld_req_ready, 0);
        tick();
        bus.squash            = 1'b0;
        bus.ld_req_valid      = '0;
        bus.mem2proc_response = 4'd1;
        #1;
        check("sqidle_cmd",   bus.proc2mem_command, BUS_STORE);
        check("sqidle_strdy", bus.st_req_ready, 1);
        tick();
        bus.mem2proc_response = '0;
        bus.st_req_valid      = 1'b0;

        // Squash in WAIT: tag 5 comes back later and must be swallowed.
        set_ld(0, 32'h0000_3000, WORD);
        #1;
        check("sqw_grant", bus.ld_req_ready, 2'b01);
        tick();
        bus.ld_req_valid      = '0;
        bus.mem2proc_response = 4'd5;
        tick();
        bus.mem2proc_response = '0;
        tick();
        bus.squash = 1'b1;
        #1;
        check("sqw_sq_rspv", bus.ld_resp_valid, 0);
        tick();
        bus.squash = 1'b0;
        set_ld(1, 32'h0000_3008, WORD);
        #1;
        check("sqw_drain_rdy", bus.ld_req_ready, 0);
        tick();
        bus.mem2proc_tag  = 4'd5;
        bus.mem2proc_data = 64'h9999_8888_7777_6666;
        #1;
        check("sqw_tag_rspv", bus.ld_resp_valid, 0);
        check("sqw_tag_rdy",  bus.ld_req_ready, 0);
        tick();
        bus.mem2proc_tag = '0;
        #1;
        check("sqw_next_grant", bus.ld_req_ready, 2'b10);
        tick();
        bus.ld_req_valid      = '0;
        bus.mem2proc_response = 4'd8;
        tick();
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = 4'd8;
        bus.mem2proc_data     = 64'h1111_2222_3333_4444;
        #1;
        check("sqw_ld1_rspv", bus.ld_resp_valid, 2'b10);
        check("sqw_ld1_rspd", bus.ld_resp_data, 32'h3333_4444);
        tick();
        bus.mem2proc_tag = '0;

        // Reset while tag 7 is outstanding.
        set_ld(0, 32'h0000_6000, WORD);
        tick();
        bus.ld_req_valid      = '0;
        bus.mem2proc_response = 4'd7;
        tick();
        bus.mem2proc_response = '0;
        tick();
        reset = 1'b1;
        tick();
        #1;
        check_all_zero("rstwait");
        tick();
        reset             = 1'b0;
        bus.mem2proc_tag  = 4'd7;
        bus.mem2proc_data = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("rstwait_tag_rspv", bus.ld_resp_valid, 0);
        check("rstwait_tag_rspd", bus.ld_resp_data, 0);
        check("rstwait_tag_cmd",  bus.proc2mem_command, BUS_NONE);
        tick();
        bus.mem2proc_tag  = '0;
        bus.mem2proc_data = '0;
        set_ld(1, 32'h0000_6008, WORD);
        #1;
        check("rstwait_grant", bus.ld_req_ready, 2'b10);
        tick();
        bus.ld_req_valid      = '0;
        bus.mem2proc_response = 4'd2;
        tick();
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = 4'd2;
        bus.mem2proc_data     = 64'h0000_0000_0BAD_F00D;
        #1;
        check("rstwait_ld1_rspv", bus.ld_resp_valid, 2'b10);
        tick();
        bus.mem2proc_tag = '0;

        // Three-way contention from reset: ld0, ld1, store, ld0, ...
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_ld(0, 32'h0000_0100, WORD);
        set_ld(1, 32'h0000_0200, WORD);
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'h0000_0300;
        bus.st_req_data  = 32'hA5A5_A5A5;
        bus.st_req_size  = WORD;
        cnt = '{0, 0, 0};
        #1;
        for (int i = 0; i < 12; i++) begin
            slot = i % 3;
            t    = 4'(i + 1);
            check("rr_grant", bus.ld_req_ready, (slot < 2) ? 64'(1 << slot) : 64'd0);
            if (bus.ld_req_ready[0]) cnt[0]++;
            if (bus.ld_req_ready[1]) cnt[1]++;
            tick();
            bus.mem2proc_response = t;
            #1;
            check("rr_cmd",   bus.proc2mem_command, (slot == 2) ? BUS_STORE : BUS_LOAD);
            check("rr_addr",  bus.proc2mem_addr, 64'(32'h100 * (slot + 1)));
            check("rr_strdy", bus.st_req_ready, (slot == 2) ? 1 : 0);
            if (bus.st_req_ready) cnt[2]++;
            tick();
            bus.mem2proc_response = '0;
            if (slot != 2) begin
                bus.mem2proc_tag  = t;
                bus.mem2proc_data = {32'h0, 32'hC0DE_0000 + 32'(i)};
                #1;
                check("rr_rspv", bus.ld_resp_valid, 64'(1 << slot));
                check("rr_rspd", bus.ld_resp_data, 32'hC0DE_0000 + 32'(i));
                tick();
                bus.mem2proc_tag  = '0;
                bus.mem2proc_data = '0;
            end
            #1;
        end
        idle_inputs();
        check("rr_cnt_ld0", cnt[0], 4);
        check("rr_cnt_ld1", cnt[1], 4);
        check("rr_cnt_st",  cnt[2], 4);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single processor-to-memory port between three requesters:
  - the two load/store functional units' load requests (one per superscalar way);
  - the store queue's retiring-store request.
- One memory transaction outstanding at a time.
- Handles the tagged memory protocol: request accept via nonzero response tag, later completion via a matching tag.
- Returns right-aligned raw load data to the requesting FU. Sign/zero extension stays in the FU.

Parameters:
- NUM_LD, 2, number of load requesters (1..4).
- XLEN, 32, data/address width.
- TAG_W, 4, memory tag width. Tag 0 means "not accepted / no completion".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  pipeline flush; cancels pending and in-flight loads
- ld_req_valid  in  NUM_LD  load request valid, per requester
- ld_req_addr  in  NUM_LD*XLEN  byte address, per requester
- ld_req_size  in  NUM_LD*2  MEM_SIZE (BYTE/HALF/WORD), per requester
- ld_req_ready  out  NUM_LD  request accepted this cycle (one-hot or zero)
- ld_resp_valid  out  NUM_LD  one-cycle load-data pulse, one-hot
- ld_resp_data  out  XLEN  right-aligned load data
- st_req_valid  in  1  retiring store valid
- st_req_addr  in  XLEN  store address
- st_req_data  in  XLEN  store data, right-aligned
- st_req_size  in  2  MEM_SIZE
- st_req_ready  out  1  store accepted by memory this cycle (store complete)
- proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2mem_addr  out  XLEN  memory address
- proc2mem_data  out  64  store data
- proc2mem_size  out  2  MEM_SIZE
- mem2proc_response  in  TAG_W  nonzero = command accepted with this tag
- mem2proc_data  in  64  completion data
- mem2proc_tag  in  TAG_W  completion tag

Behaviour:
- Reset:
  - All outputs are 0; proc2mem_command = BUS_NONE.
  - FSM goes to IDLE; rr_ptr = 0; latched request and tag are cleared.
  - Reset mid-transaction abandons it. A later matching tag is ignored.
- FSM states and transitions:
  - IDLE: pick a winner among st_req_valid and ld_req_valid[i].
    - Round-robin over NUM_LD+1 slots; the store is slot NUM_LD.
    - Search starts at rr_ptr.
    - With squash asserted, loads are not eligible.
    - Winner is latched (id, addr, size, data) and FSM moves to ISSUE in the same cycle.
    - ld_req_ready[id] pulses in that cycle for a load winner.
  - ISSUE: drive proc2mem_command/addr/size/data from the latch every cycle until mem2proc_response != 0.
    - Store accepted: st_req_ready pulses that cycle; go to IDLE; rr_ptr = NUM_LD+1 wrapped to 0.
    - Load accepted: latch the tag; go to WAIT (or DRAIN if cancelled).
    - Squash during a load ISSUE: drop the command (BUS_NONE next cycle); go to IDLE.
  - WAIT: command = BUS_NONE. When mem2proc_tag == latched tag (and nonzero):
    - ld_resp_valid[id] = 1 and ld_resp_data = mem2proc_data >> (8*addr[2:0]), truncated to XLEN and masked to size. All in that cycle, combinationally from the tag match.
    - Go to IDLE; rr_ptr = id+1 wrapped.
    - Squash in WAIT: go to DRAIN.
  - DRAIN: wait for the matching tag, produce no response, then go to IDLE.
    - A new squash in DRAIN has no effect.
- Store data: proc2mem_data = {st_data, st_data}. The memory selects bytes by addr/size.
- Stores are never squashed; once latched they complete.
- Store request must stay asserted until st_req_ready pulses. Load requests may drop at any time before ready.
- Latency:
  - Load: 1 cycle grant, plus memory accept and completion latency; response is combinational on the tag match.
  - Store: grant cycle to accept cycle.
- Simultaneous response and tag in the same cycle: only the tag for the latched transaction is considered. The response tag is captured before any completion match.
- Misaligned accesses (HALF crossing 8 bytes, etc.) are not checked; behaviour is undefined.

Decomposition:
- Shared sys_defs additions: MEM_SIZE and BUS_COMMAND enums already exist. Add the ARB_STATE enum {IDLE, ISSUE, WAIT, DRAIN} and a MEM_REQ_PACKET struct {addr, data, size, is_store, id}.
- One sub-module: rr_arbiter (parameterized N-way round-robin pick with an external pointer), reusable for the RS issue select.

Test Plan:
- Single load: ld0 addr 0x1004 WORD; mem responds tag 3 after 1 cycle, tag 3 with data 0xAABBCCDD_11223344 after 4 cycles -> ld_resp_valid = 01, data 0xAABBCCDD, exactly one pulse.
- Byte load: addr 0x1003 BYTE, data 0x...44332211 in the low word -> ld_resp_data = 0x00000044.
- Contention: ld0, ld1 and store all valid from reset -> grants in order ld0, ld1, store, then ld0 again. No requester is starved over 12 transactions.
- Accept backpressure: response = 0 for 5 cycles during a store -> command/addr stable all 5 cycles; st_req_ready pulses only on the cycle with a nonzero response.
- Squash in WAIT: load tag 5 outstanding, squash asserted, tag 5 later returns -> no ld_resp_valid; FSM back to IDLE; next request granted the following cycle.
- Reset mid-WAIT: tag 7 outstanding, reset -> all outputs 0. A later tag 7 produces no response.
